wb: RTL and testbench

Write-back stage of the swt16 pipeline, directly downstream of the memory stage. It registers the memory stage's outputs and drives the register-file write port. It mirrors that write onto a forwarding bus for the decode/execute stages. It also keeps the retired-instruction and cycle counters and runs the halt state machine that freezes the core after a halt instruction retires.

---
 rtl/wb.sv | 115 +++++++++++
 tb/tb_wb.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/wb.sv
// swt16 write-back stage: stage register, register-file write port with forwarding mirror,
// retired-instruction / cycle counters and the halt state machine.
module wb #(
   parameter int unsigned IALU_WORD_WIDTH = 16,
   parameter int unsigned OPCODE_WIDTH    = 4,
   parameter int unsigned PC_WIDTH        = 12,
   parameter int unsigned PMEM_WORD_WIDTH = 16,
   parameter int unsigned REG_IDX_WIDTH   = 4,
   parameter int unsigned CNT_WIDTH       = 32,
   parameter logic [OPCODE_WIDTH-1:0] HALT_OPCODE = 4'hF
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       in_act_write_res_to_reg,
   input  logic [2:0]                 in_cycle_in_instr,
   input  logic [PMEM_WORD_WIDTH-1:0] in_instr,
   input  logic                       in_instr_is_bubble,
   input  logic [PC_WIDTH-1:0]        in_pc,
   input  logic [IALU_WORD_WIDTH-1:0] in_res,
   input  logic [REG_IDX_WIDTH-1:0]   in_res_reg_idx,
   output logic                       out_reg_wr_en,
   output logic [REG_IDX_WIDTH-1:0]   out_reg_wr_idx,
   output logic [IALU_WORD_WIDTH-1:0] out_reg_wr_data,
   output logic                       out_fwd_valid,
   output logic [REG_IDX_WIDTH-1:0]   out_fwd_idx,
   output logic [IALU_WORD_WIDTH-1:0] out_fwd_data,
   output logic [CNT_WIDTH-1:0]       out_instret,
   output logic [CNT_WIDTH-1:0]       out_cycle_cnt,
   output logic                       out_halted,
   output logic [PC_WIDTH-1:0]        out_last_pc
);

   typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   state_t                     r_state;
   state_t                     w_state_nxt;
   logic                       r_act_ff;
   logic [2:0]                 r_cycle_ff;
   logic [PMEM_WORD_WIDTH-1:0] r_instr_ff;
   logic                       r_bubble_ff;
   logic [PC_WIDTH-1:0]        r_pc_ff;
   logic [IALU_WORD_WIDTH-1:0] r_res_ff;
   logic [REG_IDX_WIDTH-1:0]   r_idx_ff;
   logic [CNT_WIDTH-1:0]       r_instret;
   logic [CNT_WIDTH-1:0]       r_cycle_cnt;
   logic [PC_WIDTH-1:0]        r_last_pc;
   logic                       w_retire;
   logic                       w_wr_en;
   logic                       w_is_halt;

   assign w_is_halt = (r_instr_ff[PMEM_WORD_WIDTH-1 -: OPCODE_WIDTH] == HALT_OPCODE);

   always_ff @(posedge clock) begin
      if (reset) r_state <= RUN;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_retire    = 1'b0;
      w_wr_en     = 1'b0;
      case (r_state)
         RUN: begin
            w_retire = ~r_bubble_ff & (r_cycle_ff == '0);
            w_wr_en  = r_act_ff & ~r_bubble_ff;
            if (w_retire && w_is_halt) w_state_nxt = HALTED;
         end
         HALTED: w_state_nxt = HALTED;
         default: w_state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         // Reset leaves an empty slot in the stage register so the first edge out of reset retires nothing.
         r_act_ff    <= 1'b0;
         r_cycle_ff  <= '0;
         r_instr_ff  <= '0;
         r_bubble_ff <= 1'b1;
         r_pc_ff     <= '0;
         r_res_ff    <= '0;
         r_idx_ff    <= '0;
         r_instret   <= '0;
         r_cycle_cnt <= '0;
         r_last_pc   <= '0;
      end else begin
         r_act_ff    <= in_act_write_res_to_reg;
         r_cycle_ff  <= in_cycle_in_instr;
         r_instr_ff  <= in_instr;
         r_bubble_ff <= in_instr_is_bubble;
         r_pc_ff     <= in_pc;
         r_res_ff    <= in_res;
         r_idx_ff    <= in_res_reg_idx;
         if (r_state == RUN) r_cycle_cnt <= r_cycle_cnt + CNT_ONE;
         if (w_retire) begin
            r_instret <= r_instret + CNT_ONE;
            r_last_pc <= r_pc_ff;
         end
      end
   end

   assign out_reg_wr_en   = w_wr_en;
   assign out_reg_wr_idx  = r_idx_ff;
   assign out_reg_wr_data = r_res_ff;
   assign out_fwd_valid   = w_wr_en;
   assign out_fwd_idx     = r_idx_ff;
   assign out_fwd_data    = r_res_ff;
   assign out_instret     = r_instret;
   assign out_cycle_cnt   = r_cycle_cnt;
   assign out_halted      = (r_state == HALTED);
   assign out_last_pc     = r_last_pc;

endmodule

// File: tb/tb_wb.sv
// Directed-vector bench for the wb write-back stage; a second instance with 4-bit counters
// exercises counter wrap.
module tb_wb;

   logic        clock = 1'b0;
   logic        reset;
   logic        act;
   logic [2:0]  cyc;
   logic [15:0] instr;
   logic        bub;
   logic [11:0] pc;
   logic [15:0] res;
   logic [3:0]  idx;

   logic        wen, fval, halted;
   logic [3:0]  widx, fidx;
   logic [15:0] wdata, fdata;
   logic [31:0] instret, ccnt;
   logic [11:0] lpc;

   logic        wen4, fval4, halted4;
   logic [3:0]  widx4, fidx4;
   logic [15:0] wdata4, fdata4;
   logic [3:0]  instret4, ccnt4;
   logic [11:0] lpc4;

   int n_vec = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   wb dut (
      .clock(clock), .reset(reset), .in_act_write_res_to_reg(act), .in_cycle_in_instr(cyc),
      .in_instr(instr), .in_instr_is_bubble(bub), .in_pc(pc), .in_res(res), .in_res_reg_idx(idx),
      .out_reg_wr_en(wen), .out_reg_wr_idx(widx), .out_reg_wr_data(wdata),
      .out_fwd_valid(fval), .out_fwd_idx(fidx), .out_fwd_data(fdata),
      .out_instret(instret), .out_cycle_cnt(ccnt), .out_halted(halted), .out_last_pc(lpc)
   );

   wb #(.CNT_WIDTH(4)) dut4 (
      .clock(clock), .reset(reset), .in_act_write_res_to_reg(act), .in_cycle_in_instr(cyc),
      .in_instr(instr), .in_instr_is_bubble(bub), .in_pc(pc), .in_res(res), .in_res_reg_idx(idx),
      .out_reg_wr_en(wen4), .out_reg_wr_idx(widx4), .out_reg_wr_data(wdata4),
      .out_fwd_valid(fval4), .out_fwd_idx(fidx4), .out_fwd_data(fdata4),
      .out_instret(instret4), .out_cycle_cnt(ccnt4), .out_halted(halted4), .out_last_pc(lpc4)
   );

   typedef struct {
      logic        rst, a, b;
      logic [2:0]  c;
      logic [15:0] ins, rs;
      logic [11:0] p;
      logic [3:0]  ix;
      logic        e_wen;
      logic [3:0]  e_idx;
      logic [15:0] e_data;
      logic [31:0] e_inst, e_cnt;
      logic        e_halt;
      logic [11:0] e_lpc;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(logic r, logic a, logic [2:0] c, logic [15:0] ins, logic b,
                               logic [11:0] p, logic [15:0] rs, logic [3:0] ix,
                               logic ew, logic [3:0] ei, logic [15:0] ed, logic [31:0] einst,
                               logic [31:0] ecnt, logic eh, logic [11:0] elpc);
      vec_t v;
      v.rst = r; v.a = a; v.c = c; v.ins = ins; v.b = b; v.p = p; v.rs = rs; v.ix = ix;
      v.e_wen = ew; v.e_idx = ei; v.e_data = ed; v.e_inst = einst; v.e_cnt = ecnt;
      v.e_halt = eh; v.e_lpc = elpc;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic drive(input logic r, input logic a, input logic [2:0] c, input logic [15:0] ins,
                        input logic b, input logic [11:0] p, input logic [15:0] rs,
                        input logic [3:0] ix);
      reset = r; act = a; cyc = c; instr = ins; bub = b; pc = p; res = rs; idx = ix;
   endtask

   initial begin
      drive(1'b1, 1'b0, 3'd0, 16'h0, 1'b1, 12'h0, 16'h0, 4'h0);
      //            rst a  c  instr    b  pc      res      idx  | wen idx data     inst cnt halt lpc
      vq.push_back(mk(1, 0, 0, 16'h0000, 1, 12'h000, 16'h0000, 0,   0, 0, 16'h0000, 0, 0,  0, 12'h000));
      vq.push_back(mk(1, 0, 0, 16'h0000, 1, 12'h000, 16'h0000, 0,   0, 0, 16'h0000, 0, 0,  0, 12'h000));
      for (int k = 1; k <= 5; k++)
         vq.push_back(mk(0, 0, 0, 16'h0000, 1, 12'h000, 16'h0000, 0, 0, 0, 16'h0000, 0, k, 0, 12'h000));
      vq.push_back(mk(0, 1, 0, 16'h1000, 0, 12'h010, 16'hBEEF, 3,   1, 3, 16'hBEEF, 0, 6,  0, 12'h000));
      vq.push_back(mk(0, 0, 0, 16'h0000, 1, 12'h000, 16'h0000, 0,   0, 0, 16'h0000, 1, 7,  0, 12'h010));
      vq.push_back(mk(0, 1, 0, 16'h2000, 0, 12'h020, 16'h1111, 4,   1, 4, 16'h1111, 1, 8,  0, 12'h010));
      vq.push_back(mk(0, 1, 1, 16'h2000, 0, 12'h020, 16'h2222, 4,   1, 4, 16'h2222, 2, 9,  0, 12'h020));
      vq.push_back(mk(0, 1, 2, 16'h2000, 0, 12'h020, 16'h3333, 4,   1, 4, 16'h3333, 2, 10, 0, 12'h020));
      vq.push_back(mk(0, 1, 0, 16'h2000, 1, 12'h030, 16'h5555, 7,   0, 7, 16'h5555, 2, 11, 0, 12'h020));
      vq.push_back(mk(0, 0, 0, 16'h3000, 0, 12'h040, 16'h6666, 8,   0, 8, 16'h6666, 2, 12, 0, 12'h020));
      vq.push_back(mk(0, 1, 0, 16'hF000, 0, 12'h050, 16'h0007, 5,   1, 5, 16'h0007, 3, 13, 0, 12'h040));
      vq.push_back(mk(0, 1, 0, 16'h4000, 0, 12'h060, 16'h0042, 6,   0, 6, 16'h0042, 4, 14, 1, 12'h050));
      vq.push_back(mk(0, 1, 0, 16'h5000, 0, 12'h070, 16'h0099, 9,   0, 9, 16'h0099, 4, 14, 1, 12'h050));
      for (int k = 0; k < 9; k++)
         vq.push_back(mk(0, 0, 0, 16'h0000, 1, 12'h000, 16'h0000, 0, 0, 0, 16'h0000, 4, 14, 1, 12'h050));
      vq.push_back(mk(1, 1, 0, 16'h1000, 0, 12'h080, 16'hAAAA, 10,  0, 0, 16'h0000, 0, 0,  0, 12'h000));
      vq.push_back(mk(0, 1, 0, 16'h1000, 0, 12'h090, 16'hBBBB, 11,  1, 11, 16'hBBBB, 0, 1, 0, 12'h000));
      vq.push_back(mk(1, 1, 0, 16'h1000, 0, 12'h091, 16'hCCCC, 12,  0, 0, 16'h0000, 0, 0,  0, 12'h000));
      vq.push_back(mk(0, 0, 0, 16'h0000, 1, 12'h000, 16'h0000, 0,   0, 0, 16'h0000, 0, 1,  0, 12'h000));
      vq.push_back(mk(0, 1, 0, 16'h1000, 0, 12'h0A0, 16'h0101, 2,   1, 2, 16'h0101, 0, 2,  0, 12'h000));
      vq.push_back(mk(0, 1, 0, 16'h1000, 0, 12'h0A1, 16'h0202, 2,   1, 2, 16'h0202, 1, 3,  0, 12'h0A0));
      vq.push_back(mk(0, 0, 0, 16'h0000, 1, 12'h000, 16'h0000, 0,   0, 0, 16'h0000, 2, 4,  0, 12'h0A1));

      @(negedge clock);
      for (int i = 0; i < vq.size(); i++) begin
         drive(vq[i].rst, vq[i].a, vq[i].c, vq[i].ins, vq[i].b, vq[i].p, vq[i].rs, vq[i].ix);
         @(negedge clock);
         n_vec++;
         chk($sformatf("v%0d wr_en", i),    {31'd0, wen},    {31'd0, vq[i].e_wen});
         chk($sformatf("v%0d wr_idx", i),   {28'd0, widx},   {28'd0, vq[i].e_idx});
         chk($sformatf("v%0d wr_data", i),  {16'd0, wdata},  {16'd0, vq[i].e_data});
         chk($sformatf("v%0d fwd_valid", i), {31'd0, fval},  {31'd0, vq[i].e_wen});
         chk($sformatf("v%0d fwd_idx", i),  {28'd0, fidx},   {28'd0, vq[i].e_idx});
         chk($sformatf("v%0d fwd_data", i), {16'd0, fdata},  {16'd0, vq[i].e_data});
         chk($sformatf("v%0d instret", i),  instret,         vq[i].e_inst);
         chk($sformatf("v%0d cycle_cnt", i), ccnt,           vq[i].e_cnt);
         chk($sformatf("v%0d halted", i),   {31'd0, halted}, {31'd0, vq[i].e_halt});
         chk($sformatf("v%0d last_pc", i),  {20'd0, lpc},    {20'd0, vq[i].e_lpc});
      end

      // Counter wrap on the 4-bit instance: 17 retiring non-writers, then one bubble.
      drive(1'b1, 1'b0, 3'd0, 16'h0, 1'b1, 12'h0, 16'h0, 4'h0);
      @(negedge clock);
      for (int k = 0; k < 17; k++) begin
         drive(1'b0, 1'b0, 3'd0, 16'h1000, 1'b0, 12'h100 + 12'(k), 16'h0, 4'h1);
         @(negedge clock);
      end
      n_vec++;
      chk("wrap cycle_cnt4 @17", {28'd0, ccnt4},    32'd1);
      chk("wrap cycle_cnt @17",  ccnt,              32'd17);
      chk("wrap instret4 @17",   {28'd0, instret4}, 32'd0);
      chk("wrap instret @17",    instret,           32'd16);
      drive(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 12'h0, 16'h0, 4'h0);
      @(negedge clock);
      n_vec++;
      chk("wrap cycle_cnt4 @18", {28'd0, ccnt4},    32'd2);
      chk("wrap instret4 @18",   {28'd0, instret4}, 32'd1);
      chk("wrap instret @18",    instret,           32'd17);
      chk("wrap last_pc @18",    {20'd0, lpc4},     32'h110);
      chk("wrap wr_en4",         {31'd0, wen4},     32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
